neuron_act: RTL

//  Downstream companion of the rmac multiply-accumulate stage in the two-neuron datapath.

---
 rtl/neuron_pkg.sv | 27 ++
 rtl/neuron_act_fn.sv | 39 +++
 rtl/neuron_act.sv | 111 +++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and Q-format helpers for the neuron activation stage.
package neuron_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StAccum,
    StDrain,
    StOut
  } state_e;

  localparam int unsigned ACT_RELU = 0;
  localparam int unsigned ACT_HSIG = 1;

  function automatic int unsigned q_one(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  function automatic int unsigned q_half(input int unsigned frac);
    return 32'd1 << (frac - 1);
  endfunction

  function automatic int unsigned q_two(input int unsigned frac);
    return 32'd2 << frac;
  endfunction

endpackage

// File: rtl/neuron_act_fn.sv
// Combinational activation on a sign-magnitude value: ReLU or hard sigmoid.
module neuron_act_fn
  import neuron_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned ACT   = ACT_HSIG
) (
  input  logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] act
);

  localparam int unsigned MW = WIDTH - 1;
  localparam logic [MW-1:0] ONE  = MW'(q_one(FRAC));
  localparam logic [MW-1:0] HALF = MW'(q_half(FRAC));
  localparam logic [MW-1:0] TWO  = MW'(q_two(FRAC));

  logic          s;
  logic [MW-1:0] m;
  logic [MW-1:0] quarter;
  logic [MW-1:0] relu_val;
  logic [MW-1:0] hsig_val;

  assign s       = sum[WIDTH-1];
  assign m       = sum[WIDTH-2:0];
  assign quarter = m >> 2;

  always_comb begin
    relu_val = (s || (m == '0)) ? '0 : m;
    // Negative zero gives HALF - 0, the same as positive zero.
    if (m >= TWO) begin
      hsig_val = s ? '0 : ONE;
    end else begin
      hsig_val = s ? (HALF - quarter) : (HALF + quarter);
    end
    act = {1'b0, (ACT == ACT_RELU) ? relu_val : hsig_val};
  end

endmodule

// File: rtl/neuron_act.sv
// Neuron pass sequencer: clears the MAC, admits N terms, drains, activates and outputs.
module neuron_act
  import neuron_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned INT_BITS = 6,
  parameter int unsigned FRAC     = 10,
  parameter int unsigned MAC_LAT  = 1,
  parameter int unsigned CLR_CYC  = 1,
  parameter int unsigned ACT      = ACT_HSIG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mac_clr,
  input  logic [WIDTH-1:0] sum,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned CNTW = $clog2(N + 1);
  localparam int unsigned CMAX = (CLR_CYC > MAC_LAT) ? CLR_CYC : MAC_LAT;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CNTW-1:0] N_LAST   = CNTW'(N - 1);
  localparam logic [CW-1:0]   CLR_LAST = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0]   LAT_LAST = CW'(MAC_LAT - 1);

  if (INT_BITS + FRAC != WIDTH) begin : g_fmt_check
    $error("neuron_act: INT_BITS + FRAC must equal WIDTH");
  end

  state_e           state;
  logic [CNTW-1:0]  count;
  logic [CW-1:0]    cyc;
  logic [WIDTH-1:0] act_val;

  neuron_act_fn #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACT   (ACT)
  ) u_act_fn (
    .sum (sum),
    .act (act_val)
  );

  assign in_ready = (state == StAccum);
  assign busy     = (state != StIdle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      count     <= '0;
      cyc       <= '0;
      mac_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state   <= StClr;
            mac_clr <= 1'b1;
            cyc     <= '0;
            count   <= '0;
          end
        end
        StClr: begin
          if (cyc == CLR_LAST) begin
            state   <= StAccum;
            mac_clr <= 1'b0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        StAccum: begin
          if (in_valid && in_ready) begin
            count <= count + 1'b1;
            if (count == N_LAST) begin
              state <= StDrain;
              cyc   <= '0;
            end
          end
        end
        StDrain: begin
          // Sum is final on the last drain cycle; capture and present together.
          if (cyc == LAT_LAST) begin
            out_data  <= act_val;
            out_valid <= 1'b1;
            state     <= StOut;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
